memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Memory-side responder for the datapath's request unit.
- Accepts instruction-fetch (iRen) and data read/write (dRen/dWen) requests, arbitrates them onto a single external RAM port, and returns one-cycle iHit/dHit completion pulses with registered load data.
- Sits between request_unit/datapath and the RAM model; it is the counterpart that produces the hits the request unit waits on.

Parameters:
- TIMEOUT, 16: max cycles an access waits for ramready before completing with error; must be ≥1.

Ports:
- CLK      in   1   clock; rising edge
- RST      in   1   synchronous reset, active-high
- iRen     in   1   instruction read request, level, held until iHit
- iaddr    in   32  instruction address
- dRen     in   1   data read request, level, held until dHit
- dWen     in   1   data write request, level, held until dHit
- daddr    in   32  data address
- dstore   in   32  data write value
- iHit     out  1   one-cycle instruction completion pulse
- dHit     out  1   one-cycle data completion pulse
- iload    out  32  fetched instruction, valid while iHit=1, held after
- dload    out  32  loaded data, valid while dHit=1 on reads, held after
- ramREN   out  1   RAM read enable
- ramWEN   out  1   RAM write enable
- ramaddr  out  32  RAM address
- ramstore out  32  RAM write data
- ramload  in   32  RAM read data, valid when ramready=1
- ramready in   1   RAM completes current access this cycle
- mem_err  out  1   sticky: some access timed out; cleared only by RST

Behaviour:
- Reset (RST=1 at posedge):
  - All outputs go to 0; iload/dload=0; state=IDLE; wait counter=0; last_grant=INST.
  - Reset mid-access aborts the access with no hit.
- States: IDLE, DACC, IACC, RESP.
- IDLE arbitration, sampled each posedge:
  - If data requested (dRen|dWen) and iRen: grant data unless last_grant==DATA, in which case grant instruction. This alternates and prevents starvation.
  - Otherwise grant whichever is requested; none → stay IDLE.
  - Granting data → DACC, last_grant=DATA; granting instruction → IACC, last_grant=INST.
- Simultaneous dRen and dWen: treated as a write.
- DACC:
  - Combinationally drives ramaddr=daddr, ramstore=dstore, ramWEN=dWen, ramREN=dRen & ~dWen.
  - ramready=1 → latch ramload into dload (reads only; dload unchanged on writes), clear counter, go to RESP.
- IACC:
  - Drives ramaddr=iaddr, ramREN=1, ramWEN=0.
  - ramready=1 → latch ramload into iload, go to RESP.
- RAM enables are 0 in IDLE and RESP; ramaddr/ramstore=0 there.
- Wait counter:
  - Increments each DACC/IACC cycle with ramready=0.
  - When it reaches TIMEOUT-1 with ramready still 0: go to RESP without latching load data, set mem_err=1.
- RESP: asserts iHit or dHit (matching the granted side) for exactly one cycle, then IDLE unconditionally.
- Latency: request held from cycle 0 with RAM ready immediately → RAM enable in cycle 1, hit in cycle 2. Each extra RAM wait cycle adds one.
- Request dropped mid-access: access still completes and the hit is still pulsed. Requesters must not drop early.
- iHit and dHit are never both 1. A hit never occurs without a prior grant.
- Back-to-back requests: after RESP, IDLE re-arbitrates. Minimum 3 cycles per access.

Test Plan:
- Reset: assert RST 2 cycles with iRen=1 → all outputs 0, no hit; release → ramREN=1, ramaddr=iaddr next cycle.
- Data read, ramready immediate: dRen=1, daddr=0x40, ramload=0xDEADBEEF → ramREN=1 cycle 1, dHit=1 and dload=0xDEADBEEF cycle 2, dHit=0 cycle 3.
- Data write with 3 wait cycles: dWen=1, daddr=0x80, dstore=0x12345678 → ramWEN=1 for 4 cycles, dHit one pulse afterwards, dload unchanged, ramREN=0 throughout.
- Contention: iRen and dRen held, RAM always ready → grant order DATA, INST, DATA, INST; iHit/dHit alternate, never coincident.
- Timeout: iRen=1, ramready=0 forever, TIMEOUT=16 → iHit after 16 IACC cycles, mem_err=1 and stays 1 through later successful accesses until RST.
- Reset mid-access: dRen=1, RST asserted during DACC → next cycle state IDLE, ramREN=0, no dHit.

Source files
------------

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Brief    : Arbitrates instruction/data requests onto one RAM port and
//            returns one-cycle hit pulses with registered load data.
// Revision : 1.0
// ============================================================================
module memory_responder #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iRen,
    input  logic [31:0] iaddr,
    input  logic        dRen,
    input  logic        dWen,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iHit,
    output logic        dHit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        mem_err
);

    localparam int C_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DACC = 2'd1,
        S_IACC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [C_CW-1:0] r_cnt;
    logic [C_CW-1:0] w_cnt_nxt;
    logic            r_last_data;   // 1: most recent grant went to the data side
    logic [31:0]     r_iload;
    logic [31:0]     r_dload;
    logic            r_err;

    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_lat_i;
    logic            w_lat_d;
    logic            w_err_set;
    logic            w_dreq;
    logic            w_dread;
    logic            w_timeout;

    assign w_dreq    = dRen | dWen;
    assign w_dread   = dRen & ~dWen;
    assign w_timeout = ~ramready && (r_cnt == C_CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_data <= 1'b0;
            r_iload     <= '0;
            r_dload     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant_d) r_last_data <= 1'b1;
            if (w_grant_i) r_last_data <= 1'b0;
            if (w_lat_i)   r_iload     <= ramload;
            if (w_lat_d)   r_dload     <= ramload;
            if (w_err_set) r_err       <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_lat_i     = 1'b0;
        w_lat_d     = 1'b0;
        w_err_set   = 1'b0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                // On contention the side that did not win last time goes first.
                if (w_dreq && (!iRen || !r_last_data)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_DACC;
                end else if (iRen) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_IACC;
                end
            end
            S_DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWen;
                ramREN   = w_dread;
                if (ramready) begin
                    w_lat_d     = w_dread;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + C_CW'(1);
                end
            end
            S_IACC: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ramready) begin
                    w_lat_i     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + C_CW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign iHit    = (r_state == S_RESP) && !r_last_data;
    assign dHit    = (r_state == S_RESP) &&  r_last_data;
    assign iload   = r_iload;
    assign dload   = r_dload;
    assign mem_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_responder
// Brief    : Directed stimulus with a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_memory_responder;

    localparam int TIMEOUT = 16;
    localparam int SD = 1;
    localparam int SI = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iRen, dRen, dWen, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iHit, dHit, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_err    = 0;

    memory_responder #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .iRen(iRen), .iaddr(iaddr), .dRen(dRen), .dWen(dWen),
        .daddr(daddr), .dstore(dstore), .iHit(iHit), .dHit(dHit), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which side owns the RAM, how many cycles it has spent
    // there, and which side is owed a hit this cycle.
    int          m_side   = 0;
    int          m_hit    = 0;
    int          m_cycles = 0;
    int          m_last   = SI;
    logic        m_err    = 1'b0;
    logic [31:0] m_iload  = '0;
    logic [31:0] m_dload  = '0;
    bit          m_started = 1'b0;

    always @(posedge CLK) begin
        m_started <= 1'b1;
        if (RST) begin
            m_side <= 0; m_hit <= 0; m_cycles <= 0; m_last <= SI;
            m_err <= 1'b0; m_iload <= '0; m_dload <= '0;
        end else if (m_hit != 0) begin
            m_hit <= 0;
        end else if (m_side != 0) begin
            if (ramready) begin
                if (m_side == SI) m_iload <= ramload;
                else if (dRen && !dWen) m_dload <= ramload;
                m_hit  <= m_side;
                m_side <= 0;
            end else if (m_cycles == TIMEOUT) begin
                m_hit  <= m_side;
                m_side <= 0;
                m_err  <= 1'b1;
            end else begin
                m_cycles <= m_cycles + 1;
            end
        end else if ((dRen || dWen) && (!iRen || m_last == SI)) begin
            m_side <= SD; m_last <= SD; m_cycles <= 1;
        end else if (iRen) begin
            m_side <= SI; m_last <= SI; m_cycles <= 1;
        end
    end

    always @(negedge CLK) begin
        if (m_started) begin
            chk("ramREN",   ramREN,   (m_side == SI) ? 32'd1 : (m_side == SD) ? 32'(dRen && !dWen) : 32'd0);
            chk("ramWEN",   ramWEN,   32'((m_side == SD) && dWen));
            chk("ramaddr",  ramaddr,  (m_side == SI) ? iaddr : (m_side == SD) ? daddr : 32'd0);
            chk("ramstore", ramstore, (m_side == SD) ? dstore : 32'd0);
            chk("iHit",     iHit,     32'(m_hit == SI));
            chk("dHit",     dHit,     32'(m_hit == SD));
            chk("iload",    iload,    m_iload);
            chk("dload",    dload,    m_dload);
            chk("mem_err",  mem_err,  32'(m_err));
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic mid();
        @(negedge CLK); #1;
    endtask

    int hits_seen;
    int seq [4];

    initial begin
        RST = 1'b1; iRen = 1'b1; iaddr = 32'h100; dRen = 1'b0; dWen = 1'b0;
        daddr = '0; dstore = '0; ramready = 1'b0; ramload = '0;

        // Reset held two cycles with an instruction request pending
        tick(); tick();
        mid();
        chk("rst_ramREN", ramREN, 0);
        chk("rst_iHit", iHit, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_mem_err", mem_err, 0);
        RST = 1'b0;
        mid();
        chk("post_rst_ramREN", ramREN, 1);
        chk("post_rst_ramaddr", ramaddr, 32'h100);
        ramready = 1'b1; ramload = 32'hCAFEF00D;
        mid();
        chk("ifetch_iHit", iHit, 1);
        chk("ifetch_iload", iload, 32'hCAFEF00D);
        iRen = 1'b0; ramready = 1'b0;
        mid();
        chk("ifetch_iHit_gone", iHit, 0);

        // Contention: both sides held, RAM always ready
        iRen = 1'b1; iaddr = 32'h200; dRen = 1'b1; daddr = 32'h44;
        ramready = 1'b1; ramload = 32'h11110000;
        hits_seen = 0;
        for (int k = 1; k <= 11; k++) begin
            mid();
            chk("cont_exclusive", 32'(iHit && dHit), 0);
            if (iHit || dHit) begin
                if (hits_seen < 4) seq[hits_seen] = dHit ? SD : SI;
                hits_seen++;
            end
            ramload = ramload + 32'd1;
        end
        iRen = 1'b0; dRen = 1'b0; ramready = 1'b0;
        chk("cont_hits", hits_seen, 4);
        chk("cont_g0", seq[0], SD);
        chk("cont_g1", seq[1], SI);
        chk("cont_g2", seq[2], SD);
        chk("cont_g3", seq[3], SI);
        mid();

        // Data read with RAM ready immediately
        dRen = 1'b1; daddr = 32'h40; ramready = 1'b1; ramload = 32'hDEADBEEF;
        mid();
        chk("rd_ramREN", ramREN, 1);
        chk("rd_ramaddr", ramaddr, 32'h40);
        mid();
        chk("rd_dHit", dHit, 1);
        chk("rd_dload", dload, 32'hDEADBEEF);
        dRen = 1'b0; ramready = 1'b0;
        mid();
        chk("rd_dHit_gone", dHit, 0);

        // Data write with three RAM wait cycles
        dWen = 1'b1; daddr = 32'h80; dstore = 32'h12345678; ramload = 32'h55555555;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("wr_ramWEN", ramWEN, 1);
            chk("wr_ramREN", ramREN, 0);
            chk("wr_dHit_early", dHit, 0);
            if (k == 3) ramready = 1'b1;
        end
        mid();
        chk("wr_dHit", dHit, 1);
        chk("wr_dload_kept", dload, 32'hDEADBEEF);
        chk("wr_ramWEN_off", ramWEN, 0);
        dWen = 1'b0; ramready = 1'b0;
        mid();
        chk("wr_dHit_gone", dHit, 0);

        // Instruction fetch that never sees ramready
        iRen = 1'b1; iaddr = 32'h300;
        for (int k = 0; k < TIMEOUT; k++) begin
            mid();
            chk("to_waiting_iHit", iHit, 0);
            chk("to_ramREN", ramREN, 1);
        end
        mid();
        chk("to_iHit", iHit, 1);
        chk("to_mem_err", mem_err, 1);
        iRen = 1'b0;
        dRen = 1'b1; daddr = 32'h48; ramready = 1'b1; ramload = 32'h0BADF00D;
        mid(); mid(); mid();
        chk("after_to_dHit", dHit, 1);
        chk("after_to_dload", dload, 32'h0BADF00D);
        chk("err_sticky", mem_err, 1);
        dRen = 1'b0; ramready = 1'b0;
        mid();

        // Reset in the middle of a data access
        dRen = 1'b1; daddr = 32'h4C;
        mid();
        chk("abort_ramREN", ramREN, 1);
        RST = 1'b1;
        mid();
        chk("abort_ramREN_off", ramREN, 0);
        chk("abort_dHit", dHit, 0);
        chk("abort_mem_err", mem_err, 0);
        RST = 1'b0; dRen = 1'b0;
        mid();
        chk("abort_no_hit", dHit, 0);
        mid();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
